// File: rtl/datapath.sv
// Multicycle MIPS-subset datapath: PC, byte-loaded instruction register, regfile, ALU and the
// operand/address/PC muxes. All control comes from an external controller.
module datapath #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned REGBITS = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       alucontrol,
    input  logic             alusrca,
    input  logic [1:0]       alusrcb,
    input  logic             iord,
    input  logic [3:0]       irwrite,
    input  logic [WIDTH-1:0] memdata,
    input  logic             memtoreg,
    input  logic             pcen,
    input  logic [1:0]       pcsource,
    input  logic             regdst,
    input  logic             regwrite,
    output logic [WIDTH-1:0] adr,
    output logic [31:0]      instr,
    output logic [WIDTH-1:0] writedata,
    output logic             zero
);

    localparam int unsigned NREGS = 1 << REGBITS;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    logic [WIDTH-1:0]   pc, mdr, a, b, aluout;
    logic [WIDTH-1:0]   srca, srcb, aluresult, diff, nextpc, wd, rd1, rd2;
    logic [WIDTH-1:0]   jmptarget;
    logic [REGBITS-1:0] ra1, ra2, wa;
    logic [WIDTH-1:0]   rf [NREGS];

    // Register fields and write-back selection
    assign ra1       = instr[REGBITS+20:21];
    assign ra2       = instr[REGBITS+15:16];
    assign wa        = regdst ? instr[REGBITS+10:11] : instr[REGBITS+15:16];
    assign wd        = memtoreg ? mdr : aluout;
    assign jmptarget = WIDTH'({instr[WIDTH-3:0], 2'b00});

    // Register 0 is hardwired to zero on the read side as well
    assign rd1 = (ra1 == '0) ? '0 : rf[ra1];
    assign rd2 = (ra2 == '0) ? '0 : rf[ra2];

    // Operand muxes
    assign srca = alusrca ? a : pc;

    always_comb begin
        srcb = b;
        case (alusrcb)
            2'b00:   srcb = b;
            2'b01:   srcb = WIDTH'(1);
            2'b10:   srcb = instr[WIDTH-1:0];
            default: srcb = jmptarget;
        endcase
    end

    // ALU; SLT takes the sign of the raw difference, overflow is ignored
    assign diff = srca - srcb;

    always_comb begin
        aluresult = '0;
        case (alucontrol)
            ALU_AND: aluresult = srca & srcb;
            ALU_OR:  aluresult = srca | srcb;
            ALU_ADD: aluresult = srca + srcb;
            ALU_SUB: aluresult = diff;
            ALU_SLT: aluresult = {{(WIDTH-1){1'b0}}, diff[WIDTH-1]};
            default: aluresult = '0;
        endcase
    end

    assign zero = (aluresult == '0);

    // Next-PC selection
    always_comb begin
        nextpc = aluresult;
        case (pcsource)
            2'b00:   nextpc = aluresult;
            2'b01:   nextpc = aluout;
            2'b10:   nextpc = jmptarget;
            default: nextpc = '0;
        endcase
    end

    assign adr       = iord ? aluout : pc;
    assign writedata = b;

    // Program counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= '0;
        end else if (pcen) begin
            pc <= nextpc;
        end
    end

    // Instruction register, one byte lane per enable bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr <= '0;
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (irwrite[i]) begin
                    instr[8*i +: 8] <= memdata[7:0];
                end
            end
        end
    end

    // Free-running pipeline registers between the combinational stages
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mdr    <= '0;
            a      <= '0;
            b      <= '0;
            aluout <= '0;
        end else begin
            mdr    <= memdata;
            a      <= rd1;
            b      <= rd2;
            aluout <= aluresult;
        end
    end

    // Register file; writes to register 0 are dropped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                rf[i] <= '0;
            end
        end else if (regwrite && (wa != '0)) begin
            rf[wa] <= wd;
        end
    end

endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for datapath: directed scenarios plus random control sequences, all
// compared against a behavioural model of the architectural state.
module tb_datapath;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  alucontrol;
    logic        alusrca;
    logic [1:0]  alusrcb;
    logic        iord;
    logic [3:0]  irwrite;
    logic [7:0]  memdata;
    logic        memtoreg;
    logic        pcen;
    logic [1:0]  pcsource;
    logic        regdst;
    logic        regwrite;
    logic [7:0]  adr;
    logic [31:0] instr;
    logic [7:0]  writedata;
    logic        zero;

    int total = 0;
    int bad   = 0;

    // Model state
    logic [7:0]  m_pc, m_mdr, m_a, m_b, m_aluout;
    logic [31:0] m_ir;
    logic [7:0]  m_rf [8];

    datapath dut (
        .clk(clk), .reset(reset), .alucontrol(alucontrol), .alusrca(alusrca),
        .alusrcb(alusrcb), .iord(iord), .irwrite(irwrite), .memdata(memdata),
        .memtoreg(memtoreg), .pcen(pcen), .pcsource(pcsource), .regdst(regdst),
        .regwrite(regwrite), .adr(adr), .instr(instr), .writedata(writedata), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model_alu(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
        int s;
        s = int'(x) - int'(y);
        case (op)
            3'b000: return x & y;
            3'b001: return x | y;
            3'b010: return 8'((int'(x) + int'(y)) % 256);
            3'b110: return 8'((s + 256) % 256);
            3'b111: return (((s + 256) % 256) >= 128) ? 8'd1 : 8'd0;
            default: return 8'd0;
        endcase
    endfunction

    function automatic logic [7:0] model_reg(input logic [2:0] r);
        return (r == 3'd0) ? 8'd0 : m_rf[r];
    endfunction

    task automatic model_clear();
        m_pc = 0; m_mdr = 0; m_a = 0; m_b = 0; m_aluout = 0; m_ir = 0;
        for (int i = 0; i < 8; i++) m_rf[i] = 0;
    endtask

    task automatic idle();
        alucontrol = 0; alusrca = 0; alusrcb = 0; iord = 0; irwrite = 0; memdata = 0;
        memtoreg = 0; pcen = 0; pcsource = 0; regdst = 0; regwrite = 0;
    endtask

    // Called at a falling edge with inputs already set: check outputs, then advance one cycle.
    task automatic tick(input string tag);
        logic [7:0]  sa, sb, res, np, wdat, jt, r1, r2;
        logic [31:0] nir;
        logic [2:0]  wa;
        #1;
        jt = 8'(m_ir[5:0] * 4);
        sa = alusrca ? m_a : m_pc;
        case (alusrcb)
            2'd0: sb = m_b;
            2'd1: sb = 8'd1;
            2'd2: sb = m_ir[7:0];
            default: sb = jt;
        endcase
        res = model_alu(alucontrol, sa, sb);
        check({tag, ".adr"}, 32'(adr), 32'(iord ? m_aluout : m_pc));
        check({tag, ".instr"}, instr, m_ir);
        check({tag, ".wdata"}, 32'(writedata), 32'(m_b));
        check({tag, ".zero"}, 32'(zero), 32'(res == 8'd0));
        case (pcsource)
            2'd0: np = res;
            2'd1: np = m_aluout;
            2'd2: np = jt;
            default: np = 8'd0;
        endcase
        nir = m_ir;
        for (int i = 0; i < 4; i++) if (irwrite[i]) nir[8*i +: 8] = memdata;
        wa   = regdst ? m_ir[13:11] : m_ir[18:16];
        wdat = memtoreg ? m_mdr : m_aluout;
        r1   = model_reg(m_ir[23:21]);
        r2   = model_reg(m_ir[18:16]);
        @(posedge clk);
        if (pcen) m_pc = np;
        if (regwrite && wa != 3'd0) m_rf[wa] = wdat;
        m_ir = nir; m_mdr = memdata; m_a = r1; m_b = r2; m_aluout = res;
        @(negedge clk);
    endtask

    // Load one IR byte lane
    task automatic load_ir(input int lane, input logic [7:0] v);
        idle(); irwrite = 4'(1 << lane); memdata = v; tick("ir");
    endtask

    // Load register rt (via IR byte 2 = {rs,rt} field byte) with value through MDR
    task automatic load_reg(input logic [7:0] fieldbyte, input logic [7:0] v);
        load_ir(2, fieldbyte);
        idle(); memdata = v; tick("mdr");
        idle(); memtoreg = 1; regwrite = 1; tick("wb");
    endtask

    // Select A op B, latch into ALUOut, then observe it on adr
    task automatic alu_op(input string tag, input logic [2:0] op, input logic [7:0] exp);
        idle(); alusrca = 1; alucontrol = op; tick(tag);
        idle(); iord = 1; #1 check(tag, 32'(adr), 32'(exp));
    endtask

    logic [7:0] prog [4];

    initial begin
        prog[0] = 8'h20; prog[1] = 8'h08; prog[2] = 8'h43; prog[3] = 8'h00;
        idle();
        reset = 1'b1;
        model_clear();
        repeat (2) @(negedge clk);
        #1;
        check("rst.adr", 32'(adr), 32'h0);
        check("rst.instr", instr, 32'h0);
        check("rst.wdata", 32'(writedata), 32'h0);
        check("rst.zero", 32'(zero), 32'h1);
        @(negedge clk);
        reset = 1'b0;
        tick("hold"); tick("hold");
        #1 check("pc_hold", 32'(adr), 32'h0);

        // Byte-wise instruction fetch
        for (int i = 0; i < 4; i++) load_ir(i, prog[i]);
        #1 check("ir_assembled", instr, 32'h00430820);

        // PC increment through the ALU
        for (int i = 0; i < 4; i++) begin
            idle(); alusrcb = 2'b01; alucontrol = 3'b010; pcen = 1;
            #1 check("fetch_adr", 32'(adr), 32'(i));
            tick("fetch");
        end

        // r2=5, r3=7, then r1 = r2 + r3
        load_reg(8'h42, 8'd5);
        load_reg(8'h43, 8'd7);
        idle(); tick("rd");
        #1 check("b_is_r3", 32'(writedata), 32'd7);
        idle(); alusrca = 1; alucontrol = 3'b010; tick("add");
        idle(); memtoreg = 0; regdst = 1; regwrite = 1; iord = 1;
        #1 check("aluout_12", 32'(adr), 32'd12);
        tick("wb_rd");
        load_ir(2, 8'h41);
        idle(); tick("rd");
        #1 check("r1_is_12", 32'(writedata), 32'd12);

        // ALU function checks on A=r2=5, B=r3=7
        load_ir(2, 8'h43); idle(); tick("rd");
        alu_op("slt_5_7", 3'b111, 8'd1);
        alu_op("and_5_7", 3'b000, 8'd5);
        alu_op("or_5_7",  3'b001, 8'd7);
        alu_op("add_5_7", 3'b010, 8'd12);
        alu_op("undef_op", 3'b011, 8'd0);
        load_ir(2, 8'h62); idle(); tick("rd");
        alu_op("slt_7_5", 3'b111, 8'd0);
        alu_op("sub_7_5", 3'b110, 8'd2);
        load_ir(2, 8'h42); idle(); tick("rd");
        idle(); alusrca = 1; alucontrol = 3'b110;
        #1 check("sub_zero", 32'(zero), 32'd1);
        tick("sub");
        // 0xFF + 1 wraps to zero
        load_reg(8'h44, 8'hFF);
        load_ir(2, 8'h80); idle(); tick("rd");
        idle(); alusrca = 1; alusrcb = 2'b01; alucontrol = 3'b010;
        #1 check("wrap_zero", 32'(zero), 32'd1);
        tick("wrap");
        idle(); iord = 1; #1 check("wrap_res", 32'(adr), 32'd0);

        // Write to r0 is dropped
        load_reg(8'h40, 8'h55);
        idle(); tick("rd");
        #1 check("r0_zero", 32'(writedata), 32'd0);

        // Jump target from instr[5:0]
        load_ir(0, 8'h03);
        idle(); pcen = 1; pcsource = 2'b10; tick("jump");
        idle(); #1 check("jump_pc", 32'(adr), 32'h0C);

        // Random control sequences
        for (int n = 0; n < 400; n++) begin
            alucontrol = 3'($urandom); alusrca = 1'($urandom); alusrcb = 2'($urandom);
            iord = 1'($urandom); irwrite = 4'($urandom); memdata = 8'($urandom);
            memtoreg = 1'($urandom); pcen = 1'($urandom); pcsource = 2'($urandom);
            regdst = 1'($urandom); regwrite = 1'($urandom);
            tick("rand");
        end

        // Reset mid-cycle with writes pending overrides that edge
        idle(); pcen = 1; irwrite = 4'hF; regwrite = 1; memdata = 8'hA5; alusrcb = 2'b01;
        alucontrol = 3'b010;
        #2 reset = 1'b1;
        model_clear();
        #1;
        check("mid_rst.adr", 32'(adr), 32'h0);
        check("mid_rst.instr", instr, 32'h0);
        check("mid_rst.wdata", 32'(writedata), 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1 check("post_rst.instr", instr, 32'h0);
        for (int i = 0; i < 8; i++) begin
            idle(); irwrite = 4'b0100; memdata = 8'(i); tick("clr_ir");
            idle(); tick("clr_rd");
            #1 check("reg_cleared", 32'(writedata), 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
